rx_cmd_decoder: RTL

Read-domain consumer of the UART-to-APB bridge's RX FIFO. Pops received UART bytes, assembles them into read/write command frames, and hands one complete APB command at a time to the APB master over a valid/ready handshake. Detects malformed and stalled frames and reports them as single-cycle error pulses. Runs entirely on the FIFO read clock.

---
 rtl/uart_apb_pkg.sv | 22 ++
 rtl/rx_cmd_decoder_if.sv | 44 ++++
 rtl/rx_timeout_cnt.sv | 30 +++
 rtl/rx_cmd_decoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART-to-APB bridge.
// Holds the frame opcodes, error codes and the RX decoder state type.
package uart_apb_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StIssue
    } rx_state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/rx_cmd_decoder_if.sv
// RX FIFO read port plus APB command handshake for the RX command decoder.
// master = decoder side, slave = FIFO/APB-master side.
interface rx_cmd_decoder_if #(
    parameter int unsigned FIFO_WIDTH = 32
);

    logic [FIFO_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic                  fifo_ren;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [31:0]           cmd_addr;
    logic [31:0]           cmd_wdata;
    logic                  frame_err;
    logic [1:0]            err_code;

    modport master (
        input  fifo_rdata,
        input  fifo_empty,
        input  cmd_ready,
        output fifo_ren,
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        output frame_err,
        output err_code
    );

    modport slave (
        output fifo_rdata,
        output fifo_empty,
        output cmd_ready,
        input  fifo_ren,
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        input  frame_err,
        input  err_code
    );

endinterface

// File: rtl/rx_timeout_cnt.sv
// Inter-byte timeout counter: clear wins over enable, saturates at TIMEOUT.
// Shared between the RX and TX paths of the bridge.
module rx_timeout_cnt #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_BITS = $clog2(TIMEOUT + 1)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TO_BITS-1:0] r_count;
    logic               w_expired;

    assign w_expired = (r_count == TO_BITS'(TIMEOUT));
    assign o_expired = w_expired;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + TO_BITS'(1);
        end
    end

endmodule

// File: rtl/rx_cmd_decoder.sv
// Pops UART bytes from the RX FIFO, assembles opcode/address/data frames and
// presents one APB command at a time; flags bad opcodes and stalled frames.
module rx_cmd_decoder
    import uart_apb_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned TO_BITS    = $clog2(TIMEOUT + 1)
) (
    input  logic             r_clk,
    input  logic             reset,
    rx_cmd_decoder_if.master bus
);

    rx_state_e   r_state, w_state_d;
    logic        r_inflight, w_inflight_d;
    logic [1:0]  r_byte_cnt, w_byte_cnt_d;
    logic        r_cmd_valid, w_cmd_valid_d;
    logic        r_cmd_write, w_cmd_write_d;
    logic [31:0] r_cmd_addr, w_cmd_addr_d;
    logic [31:0] r_cmd_wdata, w_cmd_wdata_d;
    logic        r_frame_err, w_frame_err_d;
    logic [1:0]  r_err_code, w_err_code_d;

    logic       w_in_frame;
    logic       w_expired;
    logic       w_timeout;
    logic       w_ren;
    logic [7:0] w_byte;
    logic       w_unused_rdata;

    assign w_byte         = bus.fifo_rdata[7:0];
    assign w_unused_rdata = ^bus.fifo_rdata[FIFO_WIDTH-1:8];
    assign w_in_frame     = (r_state == StAddr) || (r_state == StData);
    assign w_timeout      = w_in_frame && w_expired;

    // Held off during reset so no byte is popped and then silently dropped.
    assign w_ren = !reset && (r_state != StIssue) && !bus.fifo_empty && !r_inflight;

    rx_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_BITS (TO_BITS)
    ) u_timeout (
        .i_clk     (r_clk),
        .i_reset   (reset),
        .i_clear   (r_inflight || !w_in_frame),
        .i_enable  (w_in_frame),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_d     = r_state;
        w_inflight_d  = w_ren && !w_timeout;
        w_byte_cnt_d  = r_byte_cnt;
        w_cmd_write_d = r_cmd_write;
        w_cmd_addr_d  = r_cmd_addr;
        w_cmd_wdata_d = r_cmd_wdata;
        w_frame_err_d = 1'b0;
        w_err_code_d  = r_err_code;

        case (r_state)
            StIdle: begin
                if (r_inflight) begin
                    if (is_opcode(w_byte)) begin
                        w_state_d     = StAddr;
                        w_cmd_write_d = (w_byte == OP_WRITE);
                        w_cmd_addr_d  = '0;
                        w_cmd_wdata_d = '0;
                        w_byte_cnt_d  = '0;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_err_code_d  = ERR_OPCODE;
                    end
                end
            end
            StAddr, StData: begin
                // A timeout discards both the captured and the just-popped byte.
                if (w_timeout) begin
                    w_state_d     = StIdle;
                    w_byte_cnt_d  = '0;
                    w_frame_err_d = 1'b1;
                    w_err_code_d  = ERR_TIMEOUT;
                end else if (r_inflight) begin
                    w_byte_cnt_d = r_byte_cnt + 2'd1;
                    if (r_state == StAddr) begin
                        w_cmd_addr_d = {r_cmd_addr[23:0], w_byte};
                        if (r_byte_cnt == 2'd3) begin
                            w_state_d = r_cmd_write ? StData : StIssue;
                            if (!r_cmd_write) begin
                                w_cmd_wdata_d = '0;
                            end
                        end
                    end else begin
                        w_cmd_wdata_d = {r_cmd_wdata[23:0], w_byte};
                        if (r_byte_cnt == 2'd3) begin
                            w_state_d = StIssue;
                        end
                    end
                end
            end
            StIssue: begin
                if (bus.cmd_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_cmd_valid_d = (w_state_d == StIssue);
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_inflight  <= 1'b0;
            r_byte_cnt  <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_frame_err <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_inflight  <= w_inflight_d;
            r_byte_cnt  <= w_byte_cnt_d;
            r_cmd_valid <= w_cmd_valid_d;
            r_cmd_write <= w_cmd_write_d;
            r_cmd_addr  <= w_cmd_addr_d;
            r_cmd_wdata <= w_cmd_wdata_d;
            r_frame_err <= w_frame_err_d;
            r_err_code  <= w_err_code_d;
        end
    end

    assign bus.fifo_ren  = w_ren;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_write = r_cmd_write;
    assign bus.cmd_addr  = r_cmd_addr;
    assign bus.cmd_wdata = r_cmd_wdata;
    assign bus.frame_err = r_frame_err;
    assign bus.err_code  = r_err_code;

endmodule
